// File: rtl/mdio_peripheral.sv
// PHY-side Clause-22 MDIO responder: oversamples MDC/MDIO on CLK, decodes frames,
// strobes writes into the register bank and shifts read data back on MDIO_IN.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR  = 5'd1,
  parameter bit         CHECK_PHY = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        MDIO_DONE,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_WTA    = 3'd2,
    S_WDATA  = 3'd3,
    S_RTA    = 3'd4,
    S_RDATA  = 3'd5,
    S_SKIP   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        mdc_s1_q, mdc_s2_q, mdc_s3_q;
  logic        dat_s1_q, dat_s2_q;
  logic        oe_s1_q, oe_s2_q;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] sh_q, sh_d;
  logic [15:0] tx_q, tx_d;
  logic        mdio_in_q, mdio_in_d;
  logic        mdio_in_oe_q, mdio_in_oe_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_stb_q, wr_stb_d;
  logic        done_q, done_d;

  logic        mdc_rise, mdc_fall;
  logic [5:0]  cnt_inc;
  logic [15:0] sh_shift;
  logic        hdr_ok;

  always_comb begin
    mdc_rise     = mdc_s2_q & ~mdc_s3_q;
    mdc_fall     = ~mdc_s2_q & mdc_s3_q;
    cnt_inc      = (cnt_q == 6'd32) ? 6'd32 : cnt_q + 6'd1;
    sh_shift     = {sh_q[14:0], dat_s2_q};
    // sh_shift[13:0] holds ST,OP,PHYAD,REGAD on the 14th rising edge
    hdr_ok       = (sh_shift[13:12] == 2'b01) &&
                   ((sh_shift[11:10] == 2'b01) || (sh_shift[11:10] == 2'b10)) &&
                   (!CHECK_PHY || (sh_shift[9:5] == PHY_ADDR));
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    tx_d         = tx_q;
    mdio_in_d    = mdio_in_q;
    mdio_in_oe_d = mdio_in_oe_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    wr_stb_d     = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mdc_rise && oe_s2_q) begin
          sh_d    = sh_shift;
          cnt_d   = 6'd1;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (mdc_rise) begin
          if (!oe_s2_q) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
          end else begin
            sh_d  = sh_shift;
            cnt_d = cnt_inc;
            if (cnt_q == 6'd13) begin
              if (!hdr_ok) begin
                state_d = S_SKIP;
              end else begin
                addr_d  = sh_shift[4:0];
                state_d = (sh_shift[11:10] == 2'b01) ? S_WTA : S_RTA;
              end
            end
          end
        end
      end
      S_WTA: begin
        if (mdc_rise) begin
          cnt_d = cnt_inc;
          if (cnt_q == 6'd15) state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        if (mdc_rise) begin
          sh_d  = sh_shift;
          cnt_d = cnt_inc;
          if (cnt_q == 6'd31) begin
            wr_data_d = sh_shift;
            wr_stb_d  = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = 6'd0;
          end
        end
      end
      S_RTA: begin
        if (mdc_rise) begin
          cnt_d = cnt_inc;
          if (cnt_q == 6'd15) begin
            tx_d    = RD_DATA;
            state_d = S_RDATA;
          end
        end
      end
      S_RDATA: begin
        if (mdc_rise) begin
          cnt_d = cnt_inc;
          if (cnt_q == 6'd31) done_d = 1'b1;
        end
        // Drive on falling edges so data is stable at the controller's rising edge
        if (mdc_fall) begin
          if (cnt_q == 6'd32) begin
            mdio_in_oe_d = 1'b0;
            mdio_in_d    = 1'b0;
            state_d      = S_IDLE;
            cnt_d        = 6'd0;
          end else begin
            mdio_in_oe_d = 1'b1;
            mdio_in_d    = tx_q[15];
            tx_d         = {tx_q[14:0], 1'b0};
          end
        end
      end
      S_SKIP: begin
        if (mdc_rise) begin
          cnt_d = cnt_inc;
          if (cnt_q == 6'd31) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      mdc_s1_q     <= 1'b0;
      mdc_s2_q     <= 1'b0;
      mdc_s3_q     <= 1'b0;
      dat_s1_q     <= 1'b0;
      dat_s2_q     <= 1'b0;
      oe_s1_q      <= 1'b0;
      oe_s2_q      <= 1'b0;
      cnt_q        <= 6'd0;
      sh_q         <= 16'd0;
      tx_q         <= 16'd0;
      mdio_in_q    <= 1'b0;
      mdio_in_oe_q <= 1'b0;
      addr_q       <= 5'd0;
      wr_data_q    <= 16'd0;
      wr_stb_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mdc_s1_q     <= MDC;
      mdc_s2_q     <= mdc_s1_q;
      mdc_s3_q     <= mdc_s2_q;
      dat_s1_q     <= MDIO_OUT;
      dat_s2_q     <= dat_s1_q;
      oe_s1_q      <= MDIO_OE;
      oe_s2_q      <= oe_s1_q;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      tx_q         <= tx_d;
      mdio_in_q    <= mdio_in_d;
      mdio_in_oe_q <= mdio_in_oe_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      wr_stb_q     <= wr_stb_d;
      done_q       <= done_d;
    end
  end

  assign MDIO_IN    = mdio_in_q;
  assign MDIO_IN_OE = mdio_in_oe_q;
  assign ADDR       = addr_q;
  assign WR_DATA    = wr_data_q;
  assign WR_STB     = wr_stb_q;
  assign MDIO_DONE  = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Bench for mdio_peripheral: a controller-side driver issues Clause-22 frames while a
// monitor pops expected writes, done pulses and read words from queues.
module tb_mdio_peripheral;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MDC;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic [15:0] RD_DATA;
  logic        MDIO_IN;
  logic        MDIO_IN_OE;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        MDIO_DONE;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [20:0] wr_exp_q[$];
  logic [4:0]  done_exp_q[$];
  logic [15:0] rd_exp_q[$];

  mdio_peripheral #(.PHY_ADDR(5'd1), .CHECK_PHY(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .MDC(MDC), .MDIO_OE(MDIO_OE), .MDIO_OUT(MDIO_OUT),
    .RD_DATA(RD_DATA), .MDIO_IN(MDIO_IN), .MDIO_IN_OE(MDIO_IN_OE), .ADDR(ADDR),
    .WR_DATA(WR_DATA), .WR_STB(WR_STB), .MDIO_DONE(MDIO_DONE), .dbg_state(dbg_state)
  );

  // clock/reset block: CLK 10 ns, MDC half period 80 ns (16 CLK per MDC)
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic mdc_bit(input logic oe, input logic b);
    MDIO_OE  = oe;
    MDIO_OUT = b;
    #80 MDC = 1'b1;
    #80 MDC = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f, input bit is_read, input int nbits);
    for (int i = 0; i < nbits; i++)
      mdc_bit(is_read ? (i < 14) : 1'b1, f[31-i]);
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [31:0] wr_frame(input logic [4:0] phy, input logic [4:0] rg,
                                           input logic [15:0] d);
    return {2'b01, 2'b01, phy, rg, 2'b10, d};
  endfunction

  function automatic logic [31:0] rd_frame(input logic [4:0] phy, input logic [4:0] rg);
    return {2'b01, 2'b10, phy, rg, 2'b00, 16'h0000};
  endfunction

  // scoreboard monitor
  int          stb_w  = 0;
  int          done_w = 0;
  logic [15:0] rd_sh  = 16'd0;
  int          rd_n   = 0;
  logic        oe_prev  = 1'b0;
  logic        mdc_prev = 1'b0;

  always @(negedge CLK) begin
    if (RESET) begin
      rd_n = 0;
    end else begin
      if (WR_STB) begin
        stb_w++;
        if (wr_exp_q.size() == 0) check("wr_stb_unexpected", 32'd1, 32'd0);
        else check("wr_addr_data", 32'({ADDR, WR_DATA}), 32'(wr_exp_q.pop_front()));
      end else if (stb_w != 0) begin
        check("wr_stb_width", 32'(stb_w), 32'd1);
        stb_w = 0;
      end
      if (MDIO_DONE) begin
        done_w++;
        if (done_exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else check("done_addr", 32'(ADDR), 32'(done_exp_q.pop_front()));
      end else if (done_w != 0) begin
        check("done_width", 32'(done_w), 32'd1);
        done_w = 0;
      end
      if (MDC && !mdc_prev && MDIO_IN_OE) begin
        rd_sh = {rd_sh[14:0], MDIO_IN};
        rd_n++;
      end
      if (oe_prev && !MDIO_IN_OE) begin
        if (rd_exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_data", 32'(rd_sh), 32'(rd_exp_q.pop_front()));
        check("rd_oe_bits", 32'(rd_n), 32'd16);
        rd_n = 0;
      end
    end
    mdc_prev = MDC;
    oe_prev  = MDIO_IN_OE;
  end

  initial begin
    RESET = 1'b1; MDC = 1'b0; MDIO_OE = 1'b0; MDIO_OUT = 1'b0; RD_DATA = 16'd0;
    idle(3);
    check("rst_mdio_in",    32'(MDIO_IN),    32'd0);
    check("rst_mdio_in_oe", 32'(MDIO_IN_OE), 32'd0);
    check("rst_addr",       32'(ADDR),       32'd0);
    check("rst_wr_data",    32'(WR_DATA),    32'd0);
    check("rst_wr_stb",     32'(WR_STB),     32'd0);
    check("rst_done",       32'(MDIO_DONE),  32'd0);
    check("rst_state",      32'(dbg_state),  32'd0);
    RESET = 1'b0;
    idle(4);

    // 1: write 3C33 to reg 2
    wr_exp_q.push_back({5'h02, 16'h3C33});
    done_exp_q.push_back(5'h02);
    send_frame(wr_frame(5'd1, 5'd2, 16'h3C33), 1'b0, 32);
    idle(20);
    check("t1_wr_data_hold", 32'(WR_DATA), 32'h3C33);
    check("t1_state_idle", 32'(dbg_state), 32'd0);

    // 2: read reg 4 returning A5C3
    RD_DATA = 16'hA5C3;
    done_exp_q.push_back(5'h04);
    rd_exp_q.push_back(16'hA5C3);
    send_frame(rd_frame(5'd1, 5'd4), 1'b1, 32);
    idle(20);
    check("t2_oe_released", 32'(MDIO_IN_OE), 32'd0);
    check("t2_wr_data_hold", 32'(WR_DATA), 32'h3C33);

    // 3: wrong PHYAD is ignored
    send_frame(wr_frame(5'd3, 5'd7, 16'hFFFF), 1'b0, 32);
    idle(20);
    check("t3_addr_unchanged", 32'(ADDR), 32'h04);
    check("t3_wr_data_unchanged", 32'(WR_DATA), 32'h3C33);
    check("t3_state_idle", 32'(dbg_state), 32'd0);

    // 4: bad ST then valid write
    send_frame({2'b00, 2'b01, 5'd1, 5'd9, 2'b10, 16'h1234}, 1'b0, 32);
    idle(20);
    check("t4_badst_addr", 32'(ADDR), 32'h04);
    wr_exp_q.push_back({5'h09, 16'hBEEF});
    done_exp_q.push_back(5'h09);
    send_frame(wr_frame(5'd1, 5'd9, 16'hBEEF), 1'b0, 32);
    idle(20);

    // 5: reset mid read data, then a full write
    RD_DATA = 16'hFFFF;
    send_frame(rd_frame(5'd1, 5'd3), 1'b1, 21);
    idle(6);
    check("t5_pre_oe", 32'(MDIO_IN_OE), 32'd1);
    check("t5_pre_in", 32'(MDIO_IN), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("t5_async_oe", 32'(MDIO_IN_OE), 32'd0);
    check("t5_async_in", 32'(MDIO_IN), 32'd0);
    check("t5_async_addr", 32'(ADDR), 32'd0);
    idle(3);
    RESET = 1'b0;
    idle(4);
    wr_exp_q.push_back({5'h11, 16'h0F0F});
    done_exp_q.push_back(5'h11);
    send_frame(wr_frame(5'd1, 5'd17, 16'h0F0F), 1'b0, 32);
    idle(20);

    // 6: write then read back-to-back
    RD_DATA = 16'h1E69;
    wr_exp_q.push_back({5'h0A, 16'hC0DE});
    done_exp_q.push_back(5'h0A);
    done_exp_q.push_back(5'h0B);
    rd_exp_q.push_back(16'h1E69);
    send_frame(wr_frame(5'd1, 5'd10, 16'hC0DE), 1'b0, 32);
    send_frame(rd_frame(5'd1, 5'd11), 1'b1, 32);
    idle(40);

    check("end_wr_q_empty",   32'(wr_exp_q.size()),   32'd0);
    check("end_done_q_empty", 32'(done_exp_q.size()), 32'd0);
    check("end_rd_q_empty",   32'(rd_exp_q.size()),   32'd0);
    check("end_state_idle",   32'(dbg_state),         32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
